// File: rtl/reg_file_2x32_wr_ctrl.sv
// Two-entry register file with a two-phase write (accept, then commit)
// and a registered read select for a downstream 2:1 mux.
module reg_file_2x32_wr_ctrl #(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_ready,
    input  logic             rd_addr,
    output logic [width-1:0] reg0_O,
    output logic [width-1:0] reg1_O,
    output logic             S,
    output logic             rd_valid,
    output logic [7:0]       wr_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               pend_addr_q, pend_addr_d;
    logic [width-1:0]   pend_data_q, pend_data_d;
    logic [width-1:0]   reg0_q, reg0_d;
    logic [width-1:0]   reg1_q, reg1_d;
    logic               s_q, s_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         wr_count_q, wr_count_d;

    // Next-state, handshakes and commit logic; a read of the register
    // being committed is held off so it observes the new value.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        reg0_d      = reg0_q;
        reg1_d      = reg1_q;
        s_d         = s_q;
        wr_count_d  = wr_count_q;

        wr_ready   = (state_q == IDLE);
        rd_ready   = !((state_q == COMMIT) && (rd_addr == pend_addr_q));
        rd_valid_d = rd_req && rd_ready;

        if (rd_valid_d) begin
            s_d = rd_addr;
        end

        unique case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    pend_addr_d = wr_addr;
                    pend_data_d = wr_data;
                    state_d     = COMMIT;
                end
            end
            COMMIT: begin
                if (pend_addr_q) begin
                    reg1_d = pend_data_q;
                end else begin
                    reg0_d = pend_data_q;
                end
                wr_count_d = wr_count_q + 8'd1;
                state_d    = IDLE;
            end
        endcase
    end

    // State and data registers; reset wins over any handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            pend_addr_q <= 1'b0;
            pend_data_q <= '0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            s_q         <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            reg0_q      <= reg0_d;
            reg1_q      <= reg1_d;
            s_q         <= s_d;
            rd_valid_q  <= rd_valid_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign reg0_O   = reg0_q;
    assign reg1_O   = reg1_q;
    assign S        = s_q;
    assign rd_valid = rd_valid_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_2x32_wr_ctrl.sv
// Bench for reg_file_2x32_wr_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_reg_file_2x32_wr_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic        rd_ready;
    logic        rd_addr;
    logic [31:0] reg0_O;
    logic [31:0] reg1_O;
    logic        S;
    logic        rd_valid;
    logic [7:0]  wr_count;

    reg_file_2x32_wr_ctrl #(.width(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .reg0_O   (reg0_O),
        .reg1_O   (reg1_O),
        .S        (S),
        .rd_valid (rd_valid),
        .wr_count (wr_count)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: a write occupies the block for two cycles
    // (accept, then land); a read lands its select one cycle later.
    bit          m_busy;
    bit          m_paddr;
    logic [31:0] m_pdata;
    logic [31:0] m_regs [2];
    bit          m_s;
    bit          m_rv;
    int          m_cnt;

    logic obs_wr_ready, obs_rd_ready;
    bit   exp_wr_ready, exp_rd_ready;

    task automatic step(input bit rst, input bit wv, input bit wa,
                        input logic [31:0] wd, input bit rr,
                        input bit ra);
        bit acc;
        RESET    = rst;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_req   = rr;
        rd_addr  = ra;
        #1;
        obs_wr_ready = wr_ready;
        obs_rd_ready = rd_ready;
        exp_wr_ready = !m_busy;
        exp_rd_ready = !(m_busy && (ra == m_paddr));
        @(posedge CLK);
        if (rst) begin
            m_busy  = 0;
            m_paddr = 0;
            m_pdata = 0;
            m_regs[0] = 0;
            m_regs[1] = 0;
            m_s   = 0;
            m_rv  = 0;
            m_cnt = 0;
        end else begin
            acc  = rr && exp_rd_ready;
            m_rv = acc;
            if (acc) m_s = ra;
            if (m_busy) begin
                m_regs[m_paddr] = m_pdata;
                m_cnt  = (m_cnt + 1) % 256;
                m_busy = 0;
            end else if (wv) begin
                m_paddr = wa;
                m_pdata = wd;
                m_busy  = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 1, 1, 32'hCAFEF00D, 1, 1);
        step(1, 0, 0, 32'h0, 0, 0);
        n_total++;
        if (reg0_O !== 32'h0)
            $display("FAIL reset_reg0 got %h want 0", reg0_O);
        else n_pass++;
        n_total++;
        if (reg1_O !== 32'h0)
            $display("FAIL reset_reg1 got %h want 0", reg1_O);
        else n_pass++;
        n_total++;
        if (S !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL reset_rd got S=%b rv=%b want 0,0",
                     S, rd_valid);
        else n_pass++;
        n_total++;
        if (wr_count !== 8'd0)
            $display("FAIL reset_cnt got %0d want 0", wr_count);
        else n_pass++;
        idle();
        n_total++;
        if (obs_wr_ready !== 1'b1 || obs_rd_ready !== 1'b1)
            $display("FAIL reset_ready got wr=%b rd=%b want 1,1",
                     obs_wr_ready, obs_rd_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        step(0, 1, 1, 32'hDEADBEEF, 0, 0);
        n_total++;
        if (obs_wr_ready !== 1'b1)
            $display("FAIL basic_accept got %b want 1", obs_wr_ready);
        else n_pass++;
        idle();
        n_total++;
        if (obs_wr_ready !== 1'b0)
            $display("FAIL basic_busy got %b want 0", obs_wr_ready);
        else n_pass++;
        n_total++;
        if (reg1_O !== 32'hDEADBEEF || wr_count !== 8'd1)
            $display("FAIL basic_commit got %h/%0d want deadbeef/1",
                     reg1_O, wr_count);
        else n_pass++;
        step(0, 0, 0, 32'h0, 1, 1);
        n_total++;
        if (S !== 1'b1 || rd_valid !== 1'b1)
            $display("FAIL basic_read got S=%b rv=%b want 1,1",
                     S, rd_valid);
        else n_pass++;
        idle();
        n_total++;
        if (rd_valid !== 1'b0 || S !== 1'b1)
            $display("FAIL basic_pulse got rv=%b S=%b want 0,1",
                     rd_valid, S);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        do_reset();
        step(0, 1, 0, 32'h11111111, 0, 0);
        idle();
        step(0, 1, 0, 32'h22222222, 1, 0);
        n_total++;
        if (rd_valid !== 1'b1 || reg0_O !== 32'h11111111)
            $display("FAIL rbw_old got rv=%b %h want 1 11111111",
                     rd_valid, reg0_O);
        else n_pass++;
        idle();
        n_total++;
        if (reg0_O !== 32'h22222222)
            $display("FAIL rbw_new got %h want 22222222", reg0_O);
        else n_pass++;
    endtask

    task automatic test_hazard();
        do_reset();
        step(0, 1, 1, 32'hA5A5A5A5, 0, 0);
        step(0, 0, 0, 32'h0, 1, 1);
        n_total++;
        if (obs_rd_ready !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL hz_stall got rdy=%b rv=%b want 0,0",
                     obs_rd_ready, rd_valid);
        else n_pass++;
        step(0, 0, 0, 32'h0, 1, 1);
        n_total++;
        if (obs_rd_ready !== 1'b1 || rd_valid !== 1'b1 || S !== 1'b1)
            $display("FAIL hz_retry got rdy=%b rv=%b S=%b want 1,1,1",
                     obs_rd_ready, rd_valid, S);
        else n_pass++;
        n_total++;
        if (reg1_O !== 32'hA5A5A5A5)
            $display("FAIL hz_data got %h want a5a5a5a5", reg1_O);
        else n_pass++;
        step(0, 1, 1, 32'h5A5A5A5A, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        n_total++;
        if (obs_rd_ready !== 1'b1 || rd_valid !== 1'b1 || S !== 1'b0)
            $display("FAIL hz_other got rdy=%b rv=%b S=%b want 1,1,0",
                     obs_rd_ready, rd_valid, S);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc;
        int bad;
        acc = 0;
        bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1'(i), $urandom, 0, 0);
            if (obs_wr_ready === 1'b1) acc++;
            if (obs_wr_ready !== 1'((i + 1) % 2)) bad++;
        end
        n_total++;
        if (acc != 5 || wr_count !== 8'd5)
            $display("FAIL b2b_count got acc=%0d cnt=%0d want 5,5",
                     acc, wr_count);
        else n_pass++;
        n_total++;
        if (bad != 0)
            $display("FAIL b2b_toggle got %0d bad cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (reg0_O !== m_regs[0] || reg1_O !== m_regs[1])
            $display("FAIL b2b_regs got %h %h want %h %h",
                     reg0_O, reg1_O, m_regs[0], m_regs[1]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(0, 1, 1'($urandom), $urandom, 0, 0);
            idle();
        end
        n_total++;
        if (wr_count !== 8'd255)
            $display("FAIL wrap_255 got %0d want 255", wr_count);
        else n_pass++;
        step(0, 1, 0, 32'h1, 0, 0);
        idle();
        n_total++;
        if (wr_count !== 8'd0)
            $display("FAIL wrap_0 got %0d want 0", wr_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_commit();
        do_reset();
        step(0, 1, 1, 32'h12345678, 0, 0);
        idle();
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        step(1, 0, 0, 32'h0, 1, 1);
        n_total++;
        if (reg0_O !== 32'h0 || reg1_O !== 32'h0 || wr_count !== 8'd0)
            $display("FAIL rmc_state got %h %h %0d want 0 0 0",
                     reg0_O, reg1_O, wr_count);
        else n_pass++;
        n_total++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL rmc_idle got rv=%b wrdy=%b want 0,1",
                     rd_valid, wr_ready);
        else n_pass++;
        idle();
        n_total++;
        if (reg0_O !== 32'h0 || wr_count !== 8'd0)
            $display("FAIL rmc_nocommit got %h %0d want 0 0",
                     reg0_O, wr_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), 1'($urandom), $urandom,
                 1'($urandom), 1'($urandom));
            n_total++;
            if (obs_wr_ready !== exp_wr_ready ||
                obs_rd_ready !== exp_rd_ready ||
                reg0_O !== m_regs[0] || reg1_O !== m_regs[1] ||
                S !== m_s || rd_valid !== m_rv ||
                wr_count !== 8'(m_cnt)) begin
                errs++;
                if (errs <= 10)
                    $display({"FAIL rand c%0d got wr%b rd%b %h %h S%b",
                              " v%b n%0d want wr%b rd%b %h %h S%b v%b n%0d"},
                             i, obs_wr_ready, obs_rd_ready, reg0_O,
                             reg1_O, S, rd_valid, wr_count,
                             exp_wr_ready, exp_rd_ready, m_regs[0],
                             m_regs[1], m_s, m_rv, m_cnt);
            end else n_pass++;
        end
    endtask

    initial begin
        RESET    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 1'b0;
        wr_data  = 32'h0;
        rd_req   = 1'b0;
        rd_addr  = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_read_before_write();
        test_hazard();
        test_back_to_back();
        test_wrap();
        test_reset_mid_commit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
